instr_issue_arbiter: RTL

Round-robin arbiter and issue stage that shares the CPU instruction port between several instruction sources, e.g. a program loader and a test/debug injector. Accepted instructions are buffered in a small FIFO and presented to the CPU one per clock. The block honours a CPU stall, supports a flush, and drives a NOP whenever no instruction is available. It sits directly in front of the CPU `instr` input and replaces direct driving of that port.

---
 rtl/cpu_pkg.sv | 5 +
 rtl/instr_fifo.sv | 44 ++++
 rtl/instr_issue_arbiter.sv | 82 ++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared instruction type and the idle NOP word (addi x0,x0,0).
package cpu_pkg;
  typedef logic [31:0] instr_t;
  localparam instr_t NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/instr_fifo.sv
// instr_fifo: DEPTH-entry synchronous FIFO with occupancy level and a clear used for flush.
module instr_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  instr_t        wdata,
  input  logic          pop,
  output instr_t        rdata,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);
  logic [AW:0] r_wr, r_rd;
  logic [AW:0] w_lvl;
  instr_t      r_mem [DEPTH];
  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign w_lvl = r_wr - r_rd;
  assign full  = w_lvl == (AW + 1)'(DEPTH);
  assign empty = r_wr == r_rd;
  assign level = LW'(w_lvl);
  assign rdata = r_mem[r_rd[AW-1:0]];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else if (clear) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (push && !full) r_wr <= r_wr + (AW + 1)'(1);
      if (pop && !empty) r_rd <= r_rd + (AW + 1)'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (push && !full && !clear) r_mem[r_wr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/instr_issue_arbiter.sv
// instr_issue_arbiter: round-robin arbitration of instruction sources into a FIFO,
// issued to the CPU one per clock with stall, flush and idle-NOP handling.
module instr_issue_arbiter
  import cpu_pkg::*;
#(
  parameter int     NREQ  = 2,
  parameter int     DEPTH = 4,
  parameter instr_t NOP   = NOP_INSTR,
  localparam int GW = $clog2(NREQ),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*32-1:0] req_instr,
  output logic [NREQ-1:0]    req_ready,
  input  logic             cpu_stall,
  input  logic             flush,
  output instr_t           instr,
  output logic             instr_valid,
  output logic [31:0]      issued_cnt,
  output logic [LW-1:0]    fifo_level
);
  logic [GW-1:0] r_ptr, w_grant, w_idx;
  logic          w_any, w_full, w_empty, w_push, w_pop;
  instr_t        w_head, w_wdata, r_instr;
  logic          r_valid;
  logic [31:0]   r_issued_cnt;
  // Scan downward so the requester closest above ptr is the last (winning) match.
  always_comb begin
    w_grant = r_ptr;
    w_any   = 1'b0;
    w_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = GW'((int'(r_ptr) + k) % NREQ);
      if (req_valid[w_idx]) begin
        w_grant = w_idx;
        w_any   = 1'b1;
      end
    end
  end
  always_comb begin
    req_ready = '0;
    if (rst && !flush && !w_full && w_any) req_ready[w_grant] = 1'b1;
  end
  assign w_push      = |(req_valid & req_ready);
  assign w_pop       = !flush && !cpu_stall && !w_empty;
  assign w_wdata     = req_instr[{w_grant, 5'b0} +: 32];
  assign instr       = r_instr;
  assign instr_valid = r_valid;
  assign issued_cnt  = r_issued_cnt;
  instr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (w_push),
    .wdata (w_wdata),
    .pop   (w_pop),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .level (fifo_level)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr        <= '0;
      r_instr      <= NOP;
      r_valid      <= 1'b0;
      r_issued_cnt <= '0;
    end else begin
      if (w_push) r_ptr <= (w_grant == GW'(NREQ - 1)) ? '0 : w_grant + GW'(1);
      if (flush) begin
        r_instr <= NOP;
        r_valid <= 1'b0;
      end else if (!cpu_stall) begin
        r_instr      <= w_empty ? NOP : w_head;
        r_valid      <= !w_empty;
        r_issued_cnt <= r_issued_cnt + {31'b0, !w_empty};
      end
    end
  end
endmodule
